// File: rtl/duty_ramp_ctrl.sv
// duty_ramp_ctrl: prescaled one-LSB-per-step duty fader with TRACK and BREATHE modes
module duty_ramp_ctrl #(
   parameter int STEP_DIV = 195313,
   parameter int WIDTH    = 8
) (
   input  logic             CLOCK_50,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             Mode,
   input  logic [WIDTH-1:0] Target,
   output logic [WIDTH-1:0] Duty,
   output logic             Dir,
   output logic             StepTick,
   output logic             AtTarget
);
   localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);
   logic [CW-1:0]    pre_cnt;
   logic [WIDTH-1:0] duty_nx;
   logic             dir_nx;
   logic             up;
   logic             dn;
   logic             zero;
   assign StepTick = Enable && (pre_cnt == LAST);
   assign AtTarget = !Mode && (Duty == Target);
   assign up       = Duty < Target;
   assign dn       = Duty > Target;
   assign zero     = Duty == '0;
   // Increments happen only when Duty<Target, so Duty can never wrap past all-ones.
   always_comb begin
      duty_nx = Duty;
      dir_nx  = Dir;
      if (!Mode) begin
         duty_nx = up ? Duty + 1'b1 : dn ? Duty - 1'b1 : Duty;
         dir_nx  = up;
      end else if (Dir) begin
         duty_nx = up ? Duty + 1'b1 : zero ? Duty : Duty - 1'b1;
         dir_nx  = up;
      end else begin
         duty_nx = !zero ? Duty - 1'b1 : (Target != '0) ? Duty + 1'b1 : Duty;
         dir_nx  = zero;
      end
   end
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         pre_cnt <= '0;
         Duty    <= '0;
         Dir     <= 1'b1;
      end else if (Enable) begin
         pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + 1'b1;
         if (StepTick) begin
            Duty <= duty_nx;
            Dir  <= dir_nx;
         end
      end
   end
endmodule
